// File: rtl/merge_batch_sched_pkg.sv
// merge_batch_sched_pkg: shared FSM encoding and batch sizing for the frame scheduler
package merge_batch_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARB       = 2'd1,
    ST_XFER      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;
  function automatic int frames_per_batch(input int thw);
    return 1 << thw;
  endfunction
endpackage

// File: rtl/merge_batch_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the slot after i_last
module rr_arbiter #(
  parameter int N  = 4,
  parameter int RW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [RW-1:0] i_last,
  output logic [N-1:0]  o_gnt_oh,
  output logic [RW-1:0] o_gnt_idx
);
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    for (int k = 1; k <= N; k++) begin
      automatic int j = (int'(i_last) + k) % N;
      if (o_gnt_oh == '0 && i_req[j]) begin
        o_gnt_oh[j] = 1'b1;
        o_gnt_idx   = RW'(j);
      end
    end
  end
endmodule

// File: rtl/merge_batch_sched.sv
// merge_batch_sched: round-robin whole-frame scheduler feeding the merge block, one batch at a time
module merge_batch_sched
  import merge_batch_sched_pkg::*;
#(
  parameter int DW   = 8,
  parameter int SHW  = 32,
  parameter int THHW = 32,
  parameter int THW  = 2,
  parameter int NREQ = 4,
  parameter int RW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      s_valid,
  input  logic [NREQ-1:0]      s_last,
  input  logic [NREQ*DW-1:0]   s_data,
  input  logic [NREQ*SHW-1:0]  s_sh,
  input  logic [NREQ*THHW-1:0] s_thh,
  output logic [NREQ-1:0]      s_ready,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [DW-1:0]        m_data,
  output logic [SHW-1:0]       m_sh,
  output logic [THHW-1:0]      m_thh,
  input  logic                 m_ready,
  input  logic                 batch_done,
  output logic [RW-1:0]        gnt_id,
  output logic [THW:0]         frame_cnt,
  output logic                 busy,
  output logic                 hdr_err
);
  localparam logic [THW:0] FPB = (THW+1)'(frames_per_batch(THW));
  state_t          r_state, w_next;
  logic [RW-1:0]   r_gnt, r_last_gnt, w_arb_idx;
  logic [NREQ-1:0] w_arb_oh;
  logic [THW:0]    r_cnt, w_cnt_inc;
  logic            r_mid, r_hdr_err;
  logic [SHW-1:0]  r_sh, w_sh;
  logic [THHW-1:0] r_thh, w_thh;
  logic            w_xfer, w_arb_any, w_hs, w_hs_last, w_hdr_beat;
  rr_arbiter #(.N(NREQ), .RW(RW)) u_arb (
    .i_req     (s_valid),
    .i_last    (r_last_gnt),
    .o_gnt_oh  (w_arb_oh),
    .o_gnt_idx (w_arb_idx)
  );
  assign w_arb_any  = |w_arb_oh;
  assign w_xfer     = r_state == ST_XFER;
  assign w_sh       = s_sh[r_gnt*SHW +: SHW];
  assign w_thh      = s_thh[r_gnt*THHW +: THHW];
  assign m_valid    = w_xfer & s_valid[r_gnt];
  assign m_last     = w_xfer & s_last[r_gnt];
  assign m_data     = w_xfer ? s_data[r_gnt*DW +: DW] : '0;
  assign m_sh       = w_xfer ? w_sh : '0;
  assign m_thh      = w_xfer ? w_thh : '0;
  assign s_ready    = w_xfer ? (NREQ'(m_ready) << r_gnt) : '0;
  assign w_hs       = m_valid & m_ready;
  assign w_hs_last  = w_hs & m_last;
  assign w_hdr_beat = w_hs & ~r_mid;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign gnt_id     = r_gnt;
  assign frame_cnt  = r_cnt;
  assign busy       = r_state != ST_IDLE;
  assign hdr_err    = r_hdr_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = |s_valid ? ST_ARB : ST_IDLE;
      ST_ARB:       w_next = w_arb_any ? ST_XFER : (r_cnt != '0 ? ST_ARB : ST_IDLE);
      ST_XFER:      w_next = !w_hs_last ? ST_XFER : (w_cnt_inc == FPB ? ST_WAIT_DONE : ST_ARB);
      ST_WAIT_DONE: w_next = batch_done ? ST_IDLE : ST_WAIT_DONE;
      default:      w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= RW'(NREQ-1);
      r_cnt      <= '0;
      r_mid      <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_sh       <= '0;
      r_thh      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_ARB && w_arb_any) r_gnt <= w_arb_idx;
      if (w_hs) r_mid <= ~m_last;
      // first frame of a batch sets the reference header the rest are checked against
      if (w_hdr_beat && r_cnt == '0) begin
        r_sh  <= w_sh;
        r_thh <= w_thh;
      end
      if (w_hdr_beat && r_cnt != '0 && (w_sh != r_sh || w_thh != r_thh)) r_hdr_err <= 1'b1;
      if (w_hs_last) begin
        r_cnt      <= w_cnt_inc;
        r_last_gnt <= r_gnt;
      end
      if (r_state == ST_WAIT_DONE && batch_done) r_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_merge_batch_sched.sv
// tb_merge_batch_sched: directed scenarios for the batch scheduler with a per-requester frame model
module tb_merge_batch_sched;
  localparam int DW = 8, SHW = 32, THHW = 32, THW = 2, NREQ = 4, RW = 2;
  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      s_valid, s_last, s_ready;
  logic [NREQ*DW-1:0]   s_data;
  logic [NREQ*SHW-1:0]  s_sh;
  logic [NREQ*THHW-1:0] s_thh;
  logic                 m_valid, m_last, m_ready, batch_done, busy, hdr_err;
  logic [DW-1:0]        m_data;
  logic [SHW-1:0]       m_sh;
  logic [THHW-1:0]      m_thh;
  logic [RW-1:0]        gnt_id;
  logic [THW:0]         frame_cnt;

  merge_batch_sched #(.DW(DW), .SHW(SHW), .THHW(THHW), .THW(THW), .NREQ(NREQ), .RW(RW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
    .s_sh(s_sh), .s_thh(s_thh), .s_ready(s_ready), .m_valid(m_valid), .m_last(m_last),
    .m_data(m_data), .m_sh(m_sh), .m_thh(m_thh), .m_ready(m_ready), .batch_done(batch_done),
    .gnt_id(gnt_id), .frame_cnt(frame_cnt), .busy(busy), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  logic [3:0] act;
  int beat[4], frm[4], len[4];
  logic mr, bd_v, bd_inject, chk_gap, hdr_exp;
  int bad_frm, bcnt, cyc, last_end;
  logic [31:0] lat_thh;
  int exp_q[$];

  function automatic logic [7:0] dat(input int r);
    return {r[1:0], frm[r][2:0], beat[r][2:0]};
  endfunction

  function automatic logic [31:0] thh_of(input int r);
    return (r == 0 && frm[r] == bad_frm) ? 32'h5 : 32'h4;
  endfunction

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      s_valid[r] = act[r];
      s_last[r]  = (beat[r] == len[r] - 1);
      s_data[r*DW +: DW]       = dat(r);
      s_sh[r*SHW +: SHW]       = 32'hA5A5_0001;
      s_thh[r*THHW +: THHW]    = thh_of(r);
    end
    m_ready    = mr;
    batch_done = bd_v | (bd_inject && frm[0] == 1);
  endtask

  task automatic clear_model();
    for (int r = 0; r < NREQ; r++) begin
      beat[r] = 0;
      frm[r]  = 0;
    end
    bcnt = 0;
    last_end = 0;
    hdr_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic cycle();
    int g;
    logic hs;
    drive();
    #1;
    hs = m_valid && m_ready;
    g = (exp_q.size() > 0) ? exp_q[0] : -1;
    total++;
    if (frame_cnt !== 3'(bcnt)) $display("FAIL frame_cnt cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, bcnt);
    else passed++;
    total++;
    if (hdr_err !== hdr_exp) $display("FAIL hdr_err cyc=%0d got=%b exp=%b", cyc, hdr_err, hdr_exp);
    else passed++;
    if (m_valid) begin
      total++;
      if (g < 0) $display("FAIL unexpected_beat cyc=%0d got s_ready=%b exp no frame", cyc, s_ready);
      else if (s_ready !== (mr ? 4'(1 << g) : 4'b0) || m_data !== dat(g) ||
               m_last !== (beat[g] == len[g] - 1) || m_thh !== thh_of(g) || m_sh !== 32'hA5A5_0001)
        $display("FAIL beat cyc=%0d got rdy=%b data=%h last=%b thh=%h exp rdy=%b data=%h last=%b thh=%h",
                 cyc, s_ready, m_data, m_last, m_thh, mr ? 4'(1 << g) : 4'b0, dat(g),
                 beat[g] == len[g] - 1, thh_of(g));
      else passed++;
    end
    @(posedge clk);
    cyc++;
    if (hs && g >= 0) begin
      if (beat[g] == 0) begin
        if (bcnt == 0) lat_thh = thh_of(g);
        else if (thh_of(g) !== lat_thh) hdr_exp = 1'b1;
        if (chk_gap && bcnt > 0) begin
          total++;
          if (cyc - last_end !== 2) $display("FAIL gap got=%0d exp=2", cyc - last_end);
          else passed++;
        end
      end
      if (beat[g] == len[g] - 1) begin
        beat[g] = 0;
        frm[g]++;
        bcnt++;
        last_end = cyc;
        void'(exp_q.pop_front());
      end else beat[g]++;
    end
    #1;
  endtask

  task automatic run_until_empty(input int max, input logic toggle);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      if (toggle) mr = ~mr;
      cycle();
      n++;
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL timeout left=%0d exp=0", exp_q.size());
    else passed++;
  endtask

  task automatic pulse_done();
    bd_v = 1'b1;
    cycle();
    bd_v = 1'b0;
    bcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    act = 4'b0;
    mr = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    act = 4'hF;
    drive();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, frame_cnt, gnt_id} !== 6'b0) $display("FAIL rst_state got busy=%b cnt=%0d gnt=%0d exp 0/0/0", busy, frame_cnt, gnt_id);
    else passed++;
    total++;
    if ({s_ready, m_valid, m_last} !== 6'b0) $display("FAIL rst_outputs got rdy=%b v=%b l=%b exp 0", s_ready, m_valid, m_last);
    else passed++;
    total++;
    if (hdr_err !== 1'b0) $display("FAIL rst_hdr got=%b exp=0", hdr_err);
    else passed++;
    reset = 1'b0;
    act = 4'b0;
    clear_model();
    cycle();
  endtask

  task automatic test_single();
    len[2] = 3;
    act = 4'b0100;
    chk_gap = 1'b1;
    exp_q = '{2, 2, 2, 2};
    run_until_empty(40, 1'b0);
    repeat (3) begin
      cycle();
      total++;
      if ({busy, s_ready, m_valid} !== 6'b100000) $display("FAIL wait_hold got busy=%b rdy=%b v=%b exp 1/0000/0", busy, s_ready, m_valid);
      else passed++;
    end
    act = 4'b0;
    pulse_done();
    total++;
    if ({busy, frame_cnt} !== 4'b0) $display("FAIL after_done got busy=%b cnt=%0d exp 0/0", busy, frame_cnt);
    else passed++;
    chk_gap = 1'b0;
  endtask

  task automatic test_rr();
    do_reset();
    len[0] = 1; len[1] = 2; len[2] = 3; len[3] = 1;
    act = 4'hF;
    chk_gap = 1'b1;
    exp_q = '{0, 1, 2, 3};
    run_until_empty(40, 1'b0);
    cycle();
    exp_q = '{0, 1, 2, 3};
    pulse_done();
    run_until_empty(40, 1'b0);
    total++;
    if (gnt_id !== 2'd3) $display("FAIL rr_last_gnt got=%0d exp=3", gnt_id);
    else passed++;
    act = 4'b0;
    pulse_done();
    chk_gap = 1'b0;
  endtask

  task automatic test_ready_toggle();
    do_reset();
    len[1] = 4;
    act = 4'b0010;
    exp_q = '{1, 1, 1, 1};
    run_until_empty(80, 1'b1);
    total++;
    if ({busy, frame_cnt, gnt_id} !== {1'b1, 3'd4, 2'd1}) $display("FAIL toggle_end got busy=%b cnt=%0d gnt=%0d exp 1/4/1", busy, frame_cnt, gnt_id);
    else passed++;
    mr = 1'b1;
    act = 4'b0;
    pulse_done();
  endtask

  task automatic test_hdr();
    do_reset();
    len[0] = 2;
    act = 4'b0001;
    bad_frm = 2;
    exp_q = '{0, 0, 0, 0};
    run_until_empty(40, 1'b0);
    total++;
    if (hdr_err !== 1'b1) $display("FAIL hdr_set got=%b exp=1", hdr_err);
    else passed++;
    act = 4'b0;
    pulse_done();
    act = 4'b0001;
    exp_q = '{0, 0, 0, 0};
    run_until_empty(40, 1'b0);
    act = 4'b0;
    pulse_done();
    total++;
    if (hdr_err !== 1'b1) $display("FAIL hdr_sticky got=%b exp=1", hdr_err);
    else passed++;
    bad_frm = -1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    len[0] = 3;
    len[3] = 1;
    act = 4'b0001;
    exp_q = '{0, 0};
    while (!(frm[0] == 1 && beat[0] == 1) && n < 30) begin
      cycle();
      n++;
    end
    total++;
    if (!(frm[0] == 1 && beat[0] == 1)) $display("FAIL reach_mid got frm=%0d beat=%0d exp 1/1", frm[0], beat[0]);
    else passed++;
    reset = 1'b1;
    act = 4'b1001;
    drive();
    @(posedge clk);
    #1;
    total++;
    if ({busy, frame_cnt, s_ready, m_valid} !== 9'b0) $display("FAIL mid_reset got busy=%b cnt=%0d rdy=%b v=%b exp 0", busy, frame_cnt, s_ready, m_valid);
    else passed++;
    reset = 1'b0;
    clear_model();
    exp_q = '{0};
    run_until_empty(20, 1'b0);
    total++;
    if (gnt_id !== 2'd0) $display("FAIL post_reset_gnt got=%0d exp=0", gnt_id);
    else passed++;
  endtask

  task automatic test_bd_ignored();
    do_reset();
    len[0] = 2;
    act = 4'b0001;
    bd_inject = 1'b1;
    exp_q = '{0, 0, 0, 0};
    run_until_empty(40, 1'b0);
    bd_inject = 1'b0;
    total++;
    if ({busy, frame_cnt} !== {1'b1, 3'd4}) $display("FAIL bd_ignored got busy=%b cnt=%0d exp 1/4", busy, frame_cnt);
    else passed++;
    act = 4'b0;
    pulse_done();
    total++;
    if (busy !== 1'b0) $display("FAIL bd_final got busy=%b exp=0", busy);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mr = 1'b1;
    bd_v = 1'b0;
    bd_inject = 1'b0;
    chk_gap = 1'b0;
    bad_frm = -1;
    act = 4'b0;
    cyc = 0;
    lat_thh = '0;
    for (int r = 0; r < NREQ; r++) len[r] = 2;
    clear_model();
    test_reset();
    test_single();
    test_rr();
    test_ready_toggle();
    test_hdr();
    test_reset_mid();
    test_bd_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/merge_batch_sched.md
# merge_batch_sched

Frame-level scheduler in front of the FIFO-based merge block. It collects complete data frames from NREQ independent requesters and feeds them, one whole frame at a time in round-robin order, into the merge block's single input port. It counts 2^THW frames per merge batch, then holds off all requesters until the merge block reports the batch drained, so batches never interleave.

## Interface
Parameters:
- DW, 8, frame data word width
- SHW, 32, side-header width
- THHW, 32, time-high-high width
- THW, 2, log2 of frames per batch (must equal the merge block's THW)
- NREQ, 4, number of requesters (2..16)
- RW, 2, requester index width, ceil(log2(NREQ))

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- s_valid  in  NREQ  per-requester beat valid
- s_last  in  NREQ  per-requester last beat of frame
- s_data  in  NREQ*DW  requester r at bits [(r+1)*DW-1 : r*DW]
- s_sh  in  NREQ*SHW  per-requester side header, same packing
- s_thh  in  NREQ*THHW  per-requester time-high-high, same packing
- s_ready  out  NREQ  per-requester ready
- m_valid  out  1  to merge i_valid
- m_last  out  1  to merge i_last
- m_data  out  DW  to merge i_data
- m_sh  out  SHW  to merge i_sh
- m_thh  out  THHW  to merge i_thh
- m_ready  in  1  from merge i_ready
- batch_done  in  1  merge o_last && o_ready (batch fully drained)
- gnt_id  out  RW  requester currently or last granted
- frame_cnt  out  THW+1  frames accepted in current batch, 0..2^THW
- busy  out  1  high in every state except IDLE
- hdr_err  out  1  sticky: a frame's sh/thh differed from the batch's first frame

## Operation
- FSM states: IDLE, ARB, XFER, WAIT_DONE.
- IDLE: if any s_valid, go to ARB.
- ARB: round-robin search starting at (last_gnt+1) mod NREQ, wrapping; first requester with s_valid high wins. Register gnt_id; go to XFER. If none valid (requester dropped valid), stay in ARB if frame_cnt>0, else return to IDLE.
- XFER: pure pass-through of requester gnt_id: m_valid=s_valid[gnt_id], m_last=s_last[gnt_id], m_data/m_sh/m_thh from that slice, s_ready[gnt_id]=m_ready; all other s_ready low. On m_valid&&m_ready&&m_last: frame_cnt+1, last_gnt<=gnt_id; if the new count equals 2^THW go to WAIT_DONE, else go to ARB.
- WAIT_DONE: all s_ready low, m_valid low. On batch_done: frame_cnt<=0, hdr_err unchanged, go to IDLE.
- Header check: on the first accepted beat of frame 0 of a batch, latch s_sh/s_thh of the granted requester. On the first beat of every later frame in the batch, compare; a mismatch sets hdr_err (cleared only by reset). The frame is still forwarded.
- A frame is never preempted: grant changes only after a handshaken last beat.
- Outside XFER: m_valid=0, m_last=0, all s_ready=0; m_data/m_sh/m_thh are don't-care and are driven 0.

## Timing
- Reset values: state IDLE, gnt_id 0, last_gnt NREQ-1 (so requester 0 wins first), frame_cnt 0, busy 0, hdr_err 0, all s_ready 0, m_valid 0, m_last 0.
- Data path is combinational in XFER: zero-cycle latency requester to merge. Ready path is combinational m_ready to s_ready.
- Gap between frames is exactly 1 cycle (the ARB cycle). Frame start latency from IDLE with s_valid high is 2 cycles: IDLE, ARB, then the first beat in XFER.
- A 1-beat frame (s_valid&&s_last on the first beat) is legal and counts as one frame.
- If batch_done is asserted in any state other than WAIT_DONE, it is ignored.
- Reset mid-frame aborts immediately; the merge block is reset alongside.

## Structure
- Shared package: FSM state encoding (IDLE=0, ARB=1, XFER=2, WAIT_DONE=3) and the frames-per-batch constant derived from THW.
- One sub-module: rr_arbiter (NREQ requests, last-grant pointer in, one-hot and index grant out, purely combinational), reusable by other multi-source blocks.

## Test plan
- Single requester: requester 2 sends four 3-beat frames, m_ready=1 -> frame_cnt steps 1,2,3,4; WAIT_DONE holds s_ready[2]=0 until batch_done; then frame_cnt=0 and state IDLE.
- All four requesters continuously valid -> grant order 0,1,2,3, then 0,... in the next batch; exactly one idle cycle between frames.
- m_ready toggled 1/0 every cycle mid-frame -> s_ready[gnt] mirrors m_ready; no beat is lost or duplicated; gnt_id stable until the last handshake.
- Frame 2 carries thh=0x5 while frame 0 carried thh=0x4 -> hdr_err=1 after frame 2's first beat and stays 1 through the following batches.
- Reset asserted during beat 2 of frame 1 -> next cycle: IDLE, frame_cnt=0, all s_ready=0, m_valid=0; the next grant goes to requester 0.
- batch_done pulse during XFER -> ignored; the batch completes normally after 4 frames.
